// File: rtl/riscv_defines.sv
// Shared fetch-side definitions: datapath width and prefetch FSM state encoding.
package riscv_defines;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID,
        WAIT_ABORT
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO holding prefetched {instruction, pc} entries; flush empties it in one cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetcher: one outstanding memory transaction at a time, responses queued
// in a small FIFO for the IF stage; branch redirects flush the queue and abort in-flight data.
//
// state       | meaning
// IDLE        | no transaction; start one when enabled and a slot is free
// WAIT_GNT    | request driven, address held until granted
// WAIT_RVALID | granted, waiting for the response to push
// WAIT_ABORT  | granted before a redirect; next response is dropped
module instr_prefetch_buffer
    import riscv_defines::fetch_state_e, riscv_defines::IDLE, riscv_defines::WAIT_GNT,
           riscv_defines::WAIT_RVALID, riscv_defines::WAIT_ABORT;
#(
    parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en_i,
    input  logic [WORD_WIDTH-1:0] boot_addr_i,
    input  logic                  branch_i,
    input  logic [WORD_WIDTH-1:0] branch_addr_i,
    output logic                  instr_req_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [WORD_WIDTH-1:0] instr_o,
    output logic [WORD_WIDTH-1:0] pc_o,
    output logic                  busy_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e            state, state_next;
    logic [WORD_WIDTH-1:0]   fetch_addr, fetch_addr_next;
    logic [WORD_WIDTH-1:0]   branch_target;
    logic [CW-1:0]           count;
    logic [CW-1:0]           count_after_push;
    logic                    space_after_push;
    logic                    fifo_full, fifo_empty;
    logic                    push, pop;
    logic [2*WORD_WIDTH-1:0] head;

    assign branch_target    = branch_addr_i & ~WORD_WIDTH'(3);
    assign valid_o          = !fifo_empty;
    assign pop              = valid_o && ready_i && !branch_i;
    assign count_after_push = count + CW'(1) - CW'(pop);
    assign space_after_push = (count_after_push < CW'(DEPTH));
    assign {instr_o, pc_o}  = head;
    assign instr_addr_o     = fetch_addr;
    assign busy_o           = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_addr <= boot_addr_i & ~WORD_WIDTH'(3);
        end else begin
            state      <= state_next;
            fetch_addr <= fetch_addr_next;
        end
    end

    always_comb begin
        state_next      = state;
        fetch_addr_next = fetch_addr;
        instr_req_o     = 1'b0;
        push            = 1'b0;
        if (branch_i) fetch_addr_next = branch_target;
        unique case (state)
            IDLE: begin
                if (fetch_en_i && (branch_i || !fifo_full)) state_next = WAIT_GNT;
            end
            WAIT_GNT: begin
                instr_req_o = 1'b1;
                if (branch_i)         state_next = instr_gnt_i ? WAIT_ABORT : IDLE;
                else if (instr_gnt_i) state_next = WAIT_RVALID;
            end
            WAIT_RVALID: begin
                if (branch_i) begin
                    // Data arriving with the redirect belongs to the old stream.
                    if (instr_rvalid_i) state_next = fetch_en_i ? WAIT_GNT : IDLE;
                    else                state_next = WAIT_ABORT;
                end else if (instr_rvalid_i) begin
                    push            = 1'b1;
                    fetch_addr_next = fetch_addr + WORD_WIDTH'(4);
                    state_next      = (fetch_en_i && space_after_push) ? WAIT_GNT : IDLE;
                end
            end
            WAIT_ABORT: begin
                if (instr_rvalid_i) state_next = (fetch_en_i && !fifo_full) ? WAIT_GNT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    fetch_fifo #(
        .WIDTH (2 * WORD_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (branch_i),
        .push  (push),
        .pop   (pop),
        .wdata ({instr_rdata_i, fetch_addr}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

endmodule

// File: doc/instr_prefetch_buffer.md
INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

Interface
REQ-001 Parameters SHALL be: WORD_WIDTH, 32, instruction/address width; DEPTH, 4, FIFO entries (power of two, >=2).
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 fetch_en_i  input  1  permits new memory requests.
REQ-005 boot_addr_i  input  WORD_WIDTH  first fetch address after reset.
REQ-006 branch_i  input  1  redirect pulse (taken branch/jump) from downstream.
REQ-007 branch_addr_i  input  WORD_WIDTH  redirect target.
REQ-008 instr_req_o  output  1  memory request.
REQ-009 instr_addr_o  output  WORD_WIDTH  request address.
REQ-010 instr_gnt_i  input  1  memory accepted the request this cycle.
REQ-011 instr_rvalid_i  input  1  instr_rdata_i valid this cycle.
REQ-012 instr_rdata_i  input  WORD_WIDTH  fetched instruction.
REQ-013 valid_o  output  1  instr_o/pc_o hold a valid entry.
REQ-014 ready_i  input  1  downstream (if_stage) consumes the entry.
REQ-015 instr_o  output  WORD_WIDTH  head instruction.
REQ-016 pc_o  output  WORD_WIDTH  address of head instruction.
REQ-017 busy_o  output  1  a transaction is outstanding or the FIFO is non-empty.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORT.
REQ-019 IDLE: when fetch_en_i=1 and (count + 0) < DEPTH, go to WAIT_GNT, driving instr_req_o=1 in WAIT_GNT only.
REQ-020 WAIT_GNT: instr_req_o and instr_addr_o SHALL stay stable until instr_gnt_i=1; on gnt go to WAIT_RVALID.
REQ-021 At most one transaction SHALL be outstanding; a request issues only if count < DEPTH (one slot reserved for its response).
REQ-022 WAIT_RVALID: on instr_rvalid_i, push {instr_rdata_i, fetch address}, fetch address += 4 (mod 2^WORD_WIDTH), next state WAIT_GNT if fetch_en_i and space, else IDLE.
REQ-023 Fetch addresses SHALL be word aligned; bits [1:0] of boot_addr_i/branch_addr_i are forced to 0.
REQ-024 valid_o = (count != 0); pop when valid_o && ready_i; instr_o/pc_o come from the FIFO head (no bypass: response-to-valid_o latency is 1 cycle).
REQ-025 Simultaneous push and pop SHALL both take effect; count unchanged.
REQ-026 branch_i SHALL flush the FIFO (count=0, valid_o=0 next cycle), ignore any same-cycle pop/push, and set fetch address to branch_addr_i.
REQ-027 branch_i in WAIT_GNT: the request may be withdrawn only if gnt is 0 that cycle; the next request uses the new address; if gnt=1 that cycle, go to WAIT_ABORT.
REQ-028 branch_i in WAIT_RVALID without rvalid: go to WAIT_ABORT; with rvalid the same cycle: discard the data and go to IDLE/WAIT_GNT.
REQ-029 WAIT_ABORT: discard the next rvalid response, no push, then resume fetching from the redirect address; a further branch_i updates the address only.
REQ-030 fetch_en_i=0 SHALL NOT cancel an in-flight request or response; it only blocks new requests.
REQ-031 instr_rvalid_i in IDLE or WAIT_GNT SHALL be ignored.

Reset
REQ-032 While rst_n=0 at the clock edge: state=IDLE, count=0, read/write pointers=0, fetch address=boot_addr_i & ~3, instr_req_o=0, valid_o=0, busy_o=0, instr_o/pc_o=0.
REQ-033 Reset mid-transaction SHALL drop the outstanding response; a late rvalid after reset is ignored per REQ-031.

Structure
REQ-034 WORD_WIDTH and the FSM state enum SHALL live in the shared riscv_defines package.
REQ-035 The storage SHALL be a sub-module fetch_fifo (parameterised width/depth, push/pop/flush, full/empty/count).

Verification
REQ-036 Reset with boot_addr_i=0x100, fetch_en_i=1, gnt immediate, rvalid one cycle later -> requests 0x100, 0x104, 0x108; pc_o=0x100 with valid_o one cycle after first rvalid.
REQ-037 ready_i=0 held -> exactly 4 entries fill, instr_req_o stays 0, count=4; one pop -> one new request issues.
REQ-038 branch_i to 0x2002 while in WAIT_RVALID -> FIFO flushed, next rvalid discarded, next request address 0x2000, first valid pc_o=0x2000.
REQ-039 gnt delayed 3 cycles -> instr_addr_o stable all 3 cycles, exactly one push.
REQ-040 Simultaneous pop and push at count=2 -> count stays 2, order preserved; at count=4 no request is outstanding.
REQ-041 Fetch address 0xFFFFFFFC -> next request 0x00000000; rst_n=0 during WAIT_RVALID -> IDLE, late rvalid ignored, valid_o=0.
